// File: rtl/mc_datapath_seq.sv
// mc_datapath_seq: multicycle RISC datapath that runs its own FETCH/DECODE/EXEC/MEM/WB sequence
// over req/ack instruction and data ports. Define MC_DP_PERF_EN to add retired/stall counters.
module mc_datapath_seq #(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0,
   localparam int             RW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   input  logic            dmem_ack_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic [XLEN-1:0] ir_o,
   input  logic [RW-1:0]   rs1_i,
   input  logic [RW-1:0]   rs2_i,
   input  logic [RW-1:0]   rd_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [3:0]      alu_func_i,
   input  logic            src_a_npc_i,
   input  logic            src_b_imm_i,
   input  logic            mem_rd_i,
   input  logic            mem_wr_i,
   input  logic            wdata_npc_i,
   input  logic            wb_en_i,
   input  logic            wb_alu_i,
   input  logic            br_en_i,
   input  logic [1:0]      br_cond_i,
   input  logic            ret_i,
   input  logic            halt_i,
`ifdef MC_DP_PERF_EN
   output logic [XLEN-1:0] perf_retired_o,
   output logic [XLEN-1:0] perf_stall_o,
`endif
   output logic [2:0]      phase_o
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [2:0] {
      PH_FETCH  = 3'd0,
      PH_DECODE = 3'd1,
      PH_EXEC   = 3'd2,
      PH_MEM    = 3'd3,
      PH_WB     = 3'd4,
      PH_HALT   = 3'd7
   } phase_e;

   phase_e                    phase_q, phase_d;
   logic [XLEN-1:0]           pc_q, pc_d;
   logic [XLEN-1:0]           ir_q, ir_d;
   logic [XLEN-1:0]           a_q, a_d;
   logic [XLEN-1:0]           b_q, b_d;
   logic [XLEN-1:0]           imm_q, imm_d;
   logic [XLEN-1:0]           alu_q, alu_d;
   logic [XLEN-1:0]           lmd_q, lmd_d;
   logic [XLEN-1:0]           npc_q, npc_d;
   logic [NREG-1:0][XLEN-1:0] rf_q;

   logic                      rf_we;
   logic [XLEN-1:0]           wb_data;
   logic [XLEN-1:0]           rs1_val, rs2_val;
   logic [XLEN-1:0]           op_a, op_b, alu_res;
   logic [SHW-1:0]            shamt;
   logic                      br_take;

   // R0 is never written, but force zero on read so the rule holds regardless of rf contents.
   assign rs1_val = (rs1_i == '0) ? '0 : rf_q[rs1_i];
   assign rs2_val = (rs2_i == '0) ? '0 : rf_q[rs2_i];
   assign wb_data = wb_alu_i ? alu_q : lmd_q;

   always_comb begin
      op_a  = src_a_npc_i ? npc_q : a_q;
      op_b  = src_b_imm_i ? imm_q : b_q;
      shamt = op_b[SHW-1:0];
      case (alu_func_i)
         4'd0:    alu_res = op_a + op_b;
         4'd1:    alu_res = op_a - op_b;
         4'd2:    alu_res = op_a & op_b;
         4'd3:    alu_res = op_a | op_b;
         4'd4:    alu_res = op_a ^ op_b;
         4'd5:    alu_res = ~op_a;
         4'd6:    alu_res = op_a << shamt;
         4'd7:    alu_res = op_a >> shamt;
         4'd8:    alu_res = $signed(op_a) >>> shamt;
         4'd9:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: alu_res = op_b;
      endcase
   end

   always_comb begin
      case (br_cond_i)
         2'b00:   br_take = (a_q == '0);
         2'b01:   br_take = ~a_q[XLEN-1] && (a_q != '0);
         2'b10:   br_take = a_q[XLEN-1];
         default: br_take = 1'b1;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      alu_d   = alu_q;
      lmd_d   = lmd_q;
      npc_d   = npc_q;
      rf_we   = 1'b0;
      case (phase_q)
         PH_FETCH: begin
            if (imem_ack_i) begin
               ir_d    = imem_rdata_i;
               npc_d   = pc_q + XLEN'(1);
               phase_d = PH_DECODE;
            end
         end
         PH_DECODE: begin
            a_d     = rs1_val;
            b_d     = rs2_val;
            imm_d   = imm_i;
            phase_d = halt_i ? PH_HALT : PH_EXEC;
         end
         PH_EXEC: begin
            alu_d   = alu_res;
            phase_d = (mem_rd_i || mem_wr_i) ? PH_MEM : PH_WB;
         end
         PH_MEM: begin
            if (dmem_ack_i) begin
               // A combined rd+wr request is a write, so LMD only follows pure reads.
               if (!mem_wr_i) lmd_d = dmem_rdata_i;
               phase_d = PH_WB;
            end
         end
         PH_WB: begin
            rf_we   = wb_en_i && (rd_i != '0);
            pc_d    = ret_i ? lmd_q : (br_en_i && br_take) ? alu_q : npc_q;
            phase_d = PH_FETCH;
         end
         PH_HALT: phase_d = PH_HALT;
         default: phase_d = PH_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_FETCH;
         pc_q    <= PC_RESET;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         lmd_q   <= '0;
         npc_q   <= '0;
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         lmd_q   <= lmd_d;
         npc_q   <= npc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rf_q        <= '0;
      else if (rf_we) rf_q[rd_i] <= wb_data;
   end

   // Fetch request is gated by rst_n so it drops the moment reset asserts.
   assign imem_req_o   = (phase_q == PH_FETCH) && rst_n;
   assign imem_addr_o  = pc_q;
   assign dmem_req_o   = (phase_q == PH_MEM);
   assign dmem_we_o    = (phase_q == PH_MEM) && mem_wr_i;
   assign dmem_addr_o  = alu_q;
   assign dmem_wdata_o = wdata_npc_i ? npc_q : b_q;
   assign ir_o         = ir_q;
   assign phase_o      = phase_q;

`ifdef MC_DP_PERF_EN
   logic [XLEN-1:0] retired_q, stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (phase_q == PH_WB) retired_q <= retired_q + XLEN'(1);
         if ((phase_q == PH_FETCH && !imem_ack_i) || (phase_q == PH_MEM && !dmem_ack_i))
            stall_q <= stall_q + XLEN'(1);
      end
   end

   assign perf_retired_o = retired_q;
   assign perf_stall_o   = stall_q;
`endif

endmodule

// File: tb/tb_mc_datapath_seq.sv
// Directed bench for mc_datapath_seq: bench acts as decoder and as imem/dmem responder.
module tb_mc_datapath_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_o, imem_ack_i;
   logic [31:0] imem_addr_o, imem_rdata_i;
   logic        dmem_req_o, dmem_we_o, dmem_ack_i;
   logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
   logic [31:0] ir_o, imm_i;
   logic [4:0]  rs1_i, rs2_i, rd_i;
   logic [3:0]  alu_func_i;
   logic        src_a_npc_i, src_b_imm_i, mem_rd_i, mem_wr_i, wdata_npc_i;
   logic        wb_en_i, wb_alu_i, br_en_i, ret_i, halt_i;
   logic [1:0]  br_cond_i;
   logic [2:0]  phase_o;
`ifdef MC_DP_PERF_EN
   logic [31:0] perf_retired_o, perf_stall_o;
`endif

   mc_datapath_seq #(.XLEN(32), .NREG(32), .PC_RESET(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
      .imem_rdata_i(imem_rdata_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .ir_o(ir_o), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .imm_i(imm_i),
      .alu_func_i(alu_func_i), .src_a_npc_i(src_a_npc_i), .src_b_imm_i(src_b_imm_i),
      .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .wdata_npc_i(wdata_npc_i),
      .wb_en_i(wb_en_i), .wb_alu_i(wb_alu_i), .br_en_i(br_en_i), .br_cond_i(br_cond_i),
      .ret_i(ret_i), .halt_i(halt_i),
`ifdef MC_DP_PERF_EN
      .perf_retired_o(perf_retired_o), .perf_stall_o(perf_stall_o),
`endif
      .phase_o(phase_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   // flag bits for issue()
   localparam logic [9:0] SBI = 10'h200, SANPC = 10'h100, MRD = 10'h080, MWR = 10'h040,
                          WNPC = 10'h020, WEN = 10'h010, WALU = 10'h008, BEN = 10'h004,
                          RET = 10'h002, HLT = 10'h001;

   // memory responder state
   int          imem_wait = 0, dmem_wait = 0;
   int          icnt = 0, dcnt = 0;
   int          i_cycles = 0;
   bit          i_stable, d_stable;
   logic [31:0] i_addr0, d_addr0, d_wdata0;
   logic        d_we0;
   logic        d_we;
   logic [31:0] d_addr, d_wdata;
   logic [31:0] instr_word = '0;
   logic [31:0] dmem [logic [31:0]];
   int          seq = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         imem_ack_i = 1'b0; dmem_ack_i = 1'b0; icnt = 0; dcnt = 0;
      end else begin
         if (imem_req_o) begin
            if (icnt == 0) begin i_addr0 = imem_addr_o; i_stable = 1'b1; end
            else if (imem_addr_o !== i_addr0) i_stable = 1'b0;
            if (icnt >= imem_wait) begin
               imem_ack_i = 1'b1; imem_rdata_i = instr_word; i_cycles = icnt + 1;
            end else imem_ack_i = 1'b0;
            icnt++;
         end else begin imem_ack_i = 1'b0; icnt = 0; end
         if (dmem_req_o) begin
            if (dcnt == 0) begin
               d_addr0 = dmem_addr_o; d_wdata0 = dmem_wdata_o; d_we0 = dmem_we_o; d_stable = 1'b1;
            end else if (dmem_addr_o !== d_addr0 || dmem_wdata_o !== d_wdata0 || dmem_we_o !== d_we0)
               d_stable = 1'b0;
            if (dcnt >= dmem_wait) begin
               dmem_ack_i = 1'b1; d_we = dmem_we_o; d_addr = dmem_addr_o; d_wdata = dmem_wdata_o;
               if (dmem_we_o) dmem[dmem_addr_o] = dmem_wdata_o;
               else dmem_rdata_i = dmem.exists(dmem_addr_o) ? dmem[dmem_addr_o] : 32'h0;
            end else dmem_ack_i = 1'b0;
            dcnt++;
         end else begin dmem_ack_i = 1'b0; dcnt = 0; end
      end
   end

   task automatic set_ctrl(input logic [3:0] f, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic [31:0] im, input logic [9:0] fl,
                           input logic [1:0] bc);
      alu_func_i = f; rs1_i = s1; rs2_i = s2; rd_i = d; imm_i = im; br_cond_i = bc;
      src_b_imm_i = fl[9]; src_a_npc_i = fl[8]; mem_rd_i = fl[7]; mem_wr_i = fl[6];
      wdata_npc_i = fl[5]; wb_en_i = fl[4]; wb_alu_i = fl[3]; br_en_i = fl[2];
      ret_i = fl[1]; halt_i = fl[0];
   endtask

   // Runs one instruction from FETCH until the next FETCH (or HALTED); returns cycle count.
   task automatic issue(input logic [3:0] f, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [31:0] im, input logic [9:0] fl,
                        input logic [1:0] bc, input int iw, input int dw, output int cyc);
      bit left = 1'b0;
      set_ctrl(f, s1, s2, d, im, fl, bc);
      imem_wait = iw; dmem_wait = dw;
      instr_word = 32'hC0DE_0000 + seq; seq++;
      cyc = 0;
      while (cyc < 64) begin
         @(posedge clk); #1; cyc++;
         if (phase_o == 3'd7) break;
         if (left && phase_o == 3'd0) break;
         if (phase_o != 3'd0) left = 1'b1;
      end
      if (cyc >= 64) begin
         n_tests++; n_fail++;
         $display("FAIL issue_timeout: phase %0d after %0d cycles, required return to FETCH", phase_o, cyc);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [4:0] src, output int cyc);
      issue(4'd0, 5'd0, src, 5'd0, addr, SBI | MWR, 2'b00, 0, 0, cyc);
   endtask

   task automatic test_reset;
      set_ctrl(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 10'h0, 2'b00);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_phase", {29'h0, phase_o}, 32'd0);
      chk("reset_imem_req", {31'h0, imem_req_o}, 32'd0);
      chk("reset_pc", imem_addr_o, 32'h0);
      chk("reset_ir", ir_o, 32'h0);
      chk("reset_dmem", {30'h0, dmem_req_o, dmem_we_o}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1; #1;
      chk("post_reset_imem_req", {31'h0, imem_req_o}, 32'd1);
   endtask

   task automatic test_addi;
      int cyc;
      issue(4'd0, 5'd0, 5'd0, 5'd1, 32'd5, SBI | WEN | WALU, 2'b00, 0, 0, cyc);
      chk("addi_latency", cyc, 32'd4);
      chk("addi_ir", ir_o, 32'hC0DE_0000);
      chk("addi_pc", imem_addr_o, 32'd1);
   endtask

   task automatic test_fetch_wait;
      int cyc;
      issue(4'd10, 5'd0, 5'd0, 5'd0, 32'h0, 10'h0, 2'b00, 3, 0, cyc);
      chk("fetchwait_req_cycles", i_cycles, 32'd4);
      chk("fetchwait_addr_stable", {31'h0, i_stable}, 32'd1);
      chk("fetchwait_latency", cyc, 32'd7);
      chk("fetchwait_pc", imem_addr_o, 32'd2);
`ifdef MC_DP_PERF_EN
      chk("perf_stall", perf_stall_o, 32'd3);
      chk("perf_retired", perf_retired_o, 32'd2);
`endif
   endtask

   task automatic test_store_load;
      int cyc;
      issue(4'd0, 5'd0, 5'd0, 5'd2, 32'h1234, SBI | WEN | WALU, 2'b00, 0, 0, cyc);
      store(32'd4, 5'd1, cyc);
      chk("r1_via_store", d_wdata, 32'd5);
      store(32'd8, 5'd2, cyc);
      chk("store_latency", cyc, 32'd5);
      chk("store_we", {31'h0, d_we}, 32'd1);
      chk("store_addr", d_addr, 32'd8);
      chk("store_wdata", d_wdata, 32'h1234);
      issue(4'd0, 5'd0, 5'd0, 5'd3, 32'd8, SBI | MRD | WEN, 2'b00, 0, 2, cyc);
      chk("load_we", {31'h0, d_we}, 32'd0);
      chk("load_stable", {31'h0, d_stable}, 32'd1);
      chk("load_latency", cyc, 32'd7);
      store(32'd12, 5'd3, cyc);
      chk("load_r3", d_wdata, 32'h1234);
      chk("store_load_pc", imem_addr_o, 32'd7);
   endtask

   task automatic test_branch;
      int cyc;
      issue(4'd10, 5'd0, 5'd0, 5'd0, 32'd20, SBI | BEN, 2'b00, 0, 0, cyc);
      chk("br_eqz_taken", imem_addr_o, 32'd20);
      issue(4'd0, 5'd0, 5'd0, 5'd4, 32'hFFFF_FFFF, SBI | WEN | WALU, 2'b00, 0, 0, cyc);
      issue(4'd10, 5'd4, 5'd0, 5'd0, 32'd20, SBI | BEN, 2'b00, 0, 0, cyc);
      chk("br_eqz_not_taken", imem_addr_o, 32'd22);
      issue(4'd10, 5'd4, 5'd0, 5'd0, 32'd20, SBI | BEN, 2'b10, 0, 0, cyc);
      chk("br_ltz_taken", imem_addr_o, 32'd20);
      issue(4'd10, 5'd4, 5'd0, 5'd0, 32'd40, SBI | BEN, 2'b01, 0, 0, cyc);
      chk("br_gtz_neg", imem_addr_o, 32'd21);
      issue(4'd10, 5'd1, 5'd0, 5'd0, 32'd40, SBI | BEN, 2'b01, 0, 0, cyc);
      chk("br_gtz_pos", imem_addr_o, 32'd40);
   endtask

   task automatic test_call_ret;
      int cyc;
      issue(4'd0, 5'd0, 5'd0, 5'd0, 32'd100, SBI | MWR | WNPC | BEN | WEN | WALU, 2'b11, 0, 0, cyc);
      chk("call_wdata_npc", d_wdata, 32'd41);
      chk("call_addr", d_addr, 32'd100);
      chk("call_pc", imem_addr_o, 32'd100);
      issue(4'd0, 5'd0, 5'd0, 5'd0, 32'd100, SBI | MRD | RET | BEN | WEN, 2'b11, 0, 0, cyc);
      chk("ret_pc", imem_addr_o, 32'd41);
      store(32'd0, 5'd0, cyc);
      chk("r0_zero", d_wdata, 32'd0);
   endtask

   task automatic test_alu;
      logic [3:0]  f  [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd0, 4'd0, 4'd12};
      logic [4:0]  s1 [13] = '{5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd4, 5'd4, 5'd4, 5'd1, 5'd4, 5'd0, 5'd0};
      logic [4:0]  s2 [13] = '{5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd4, 5'd0, 5'd0, 5'd0};
      logic [9:0]  fl [13] = '{MWR, SBI|MWR, SBI|MWR, MWR, MWR, SBI|MWR, SBI|MWR, SBI|MWR,
                               MWR, MWR, SBI|MWR, SANPC|SBI|MWR, SBI|MWR};
      logic [31:0] im [13] = '{32'h0, 32'hFF, 32'h100, 32'h0, 32'h0, 32'h24, 32'd28, 32'd4,
                               32'h0, 32'h0, 32'd1, 32'h0, 32'h77};
      logic [31:0] ex [13] = '{32'hFFFF_EDD1, 32'h34, 32'h105, 32'h1231, 32'hFFFF_FFFA, 32'h50,
                               32'hF, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd54, 32'h77};
      int cyc;
      for (int i = 0; i < 13; i++) begin
         issue(f[i], s1[i], s2[i], 5'd0, im[i], fl[i], 2'b00, 0, 0, cyc);
         n_tests++;
         if (d_addr !== ex[i]) begin
            n_fail++;
            $display("FAIL alu_%0d (func %0d): got 0x%08h required 0x%08h", i, f[i], d_addr, ex[i]);
         end
      end
      chk("alu_pc", imem_addr_o, 32'd55);
   endtask

   task automatic test_halt;
      int cyc;
      bit quiet = 1'b1;
      issue(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, HLT, 2'b00, 0, 0, cyc);
      chk("halt_phase", {29'h0, phase_o}, 32'd7);
      repeat (5) begin
         @(posedge clk); #1;
         if (imem_req_o !== 1'b0 || dmem_req_o !== 1'b0 || phase_o !== 3'd7) quiet = 1'b0;
      end
      chk("halt_no_requests", {31'h0, quiet}, 32'd1);
      chk("halt_pc_frozen", imem_addr_o, 32'd55);
   endtask

   task automatic test_reset_mid_mem;
      int cyc;
      int n = 0;
      rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
      issue(4'd0, 5'd0, 5'd0, 5'd1, 32'd9, SBI | WEN | WALU, 2'b00, 0, 0, cyc);
      chk("restart_pc", imem_addr_o, 32'd1);
      set_ctrl(4'd0, 5'd0, 5'd1, 5'd0, 32'd16, SBI | MWR, 2'b00);
      dmem_wait = 20;
      while (phase_o != 3'd3 && n < 20) begin @(posedge clk); #1; n++; end
      chk("midmem_req_before", {31'h0, dmem_req_o}, 32'd1);
      rst_n = 1'b0; #1;
      chk("midmem_dmem_req", {30'h0, dmem_req_o, dmem_we_o}, 32'd0);
      chk("midmem_pc", imem_addr_o, 32'd0);
      chk("midmem_phase", {29'h0, phase_o}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   initial begin
      imem_ack_i = 1'b0; dmem_ack_i = 1'b0; imem_rdata_i = '0; dmem_rdata_i = '0;
      test_reset;
      test_addi;
      test_fetch_wait;
      test_store_load;
      test_branch;
      test_call_ret;
      test_alu;
      test_halt;
      test_reset_mid_mem;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
